// File: rtl/ecall_service_unit.sv
// ecall_service_unit: services ECALLs from retiring instructions (print-int, print-char, exit,
// exit-with-code) and buffers print requests in a FIFO drained over valid/ready.
// The FIFO applies stall back-pressure to the core. A no-retire watchdog can force a halt.
// A halt drains the FIFO before the block stops, and unknown service codes set a sticky error.
// Optional macro ECALL_COUNTERS_EN builds 64-bit cycle/instret counters (tied to 0 otherwise).
// Ports:
//    clock, reset           rising-edge clock, synchronous active-high reset
//    retire_valid           retire strobe, with instruction/pc/a0/a1 of the retiring instruction
//    stall                  combinational hold request (print ECALL hits a full FIFO)
//    out_valid/kind/data    FIFO head (kind 0=int, 1=char), popped by out_ready
//    halt, done, halt_code  halt request to the core, drained-and-halted flag, exit status
//    err                    sticky unknown-service-code flag
//    cycle_count            cycle counter (0 unless ECALL_COUNTERS_EN)
//    instret_count          retired-instruction counter (0 unless ECALL_COUNTERS_EN)
module ecall_service_unit #(
   parameter int XLEN        = 32,
   parameter int FIFO_DEPTH  = 8,
   parameter int WDOG_CYCLES = 100000
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            retire_valid,
   input  logic [31:0]     instruction,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] a0,
   input  logic [XLEN-1:0] a1,
   output logic            stall,
   output logic            out_valid,
   output logic            out_kind,
   output logic [XLEN-1:0] out_data,
   input  logic            out_ready,
   output logic            halt,
   output logic            done,
   output logic [XLEN-1:0] halt_code,
   output logic            err,
   output logic [63:0]     cycle_count,
   output logic [63:0]     instret_count
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES + 1) : 1;
   typedef enum logic [1:0] {RUN, HALTING, HALTED} state_t;
   state_t            state_q, state_d;
   logic [XLEN:0]     mem_q [FIFO_DEPTH];
   logic [XLEN:0]     mem_d [FIFO_DEPTH];
   logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]       count_q, count_d;
   logic [WW-1:0]     wdog_q, wdog_d;
   logic [XLEN-1:0]   halt_code_q, halt_code_d;
   logic              err_q, err_d, seen_q, seen_d;
   logic              is_ecall, is_print, is_exit, is_exit_code, full, run, accept, push, pop;
   logic              pcz_hit, wdog_hit, halt_cause;
   logic [XLEN-1:0]   cause_code;
   assign run          = state_q == RUN;
   assign is_ecall     = retire_valid && instruction == 32'h0000_0073;
   assign is_print     = is_ecall && (a0 == XLEN'(1) || a0 == XLEN'(11));
   assign is_exit      = is_ecall && a0 == XLEN'(10);
   assign is_exit_code = is_ecall && a0 == XLEN'(93);
   assign full         = count_q == (AW+1)'(FIFO_DEPTH);
   // Stall ignores a same-cycle pop so that it depends only on registered FIFO state.
   assign stall        = is_print && full && run;
   assign accept       = retire_valid && !stall && run;
   assign push         = accept && is_print;
   assign out_valid    = count_q != '0;
   assign pop          = out_valid && out_ready;
   assign out_kind     = out_valid ? mem_q[rd_q][XLEN] : 1'b0;
   assign out_data     = out_valid ? mem_q[rd_q][XLEN-1:0] : '0;
   // pc==0 after an earlier retire means the program jumped through a null pointer or returned off main.
   assign pcz_hit      = accept && seen_q && pc == '0;
   assign wdog_hit     = WDOG_CYCLES != 0 && run && !accept && 32'(wdog_q) + 32'd1 == 32'(WDOG_CYCLES);
   assign halt_cause   = (accept && (is_exit || is_exit_code)) || pcz_hit || wdog_hit;
   assign cause_code   = (accept && is_exit_code) ? a1 :
                         (accept && is_exit) ? '0 :
                         pcz_hit ? '1 : XLEN'(32'hDEAD_0001);
   assign halt         = state_q != RUN;
   assign done         = state_q == HALTED;
   assign halt_code    = halt_code_q;
   assign err          = err_q;
   always_comb begin
      mem_d       = mem_q;
      wr_d        = wr_q + AW'(push);
      rd_d        = rd_q + AW'(pop);
      count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
      seen_d      = seen_q || accept;
      err_d       = err_q || (accept && is_ecall && !is_print && !is_exit && !is_exit_code);
      wdog_d      = (!run || accept || WDOG_CYCLES == 0) ? '0 : wdog_q + 1'b1;
      halt_code_d = (run && halt_cause) ? cause_code : halt_code_q;
      state_d     = state_q;
      if (push)
         mem_d[wr_q] = a0 == XLEN'(11) ? {1'b1, XLEN'(a1[7:0])} : {1'b0, a1};
      case (state_q)
         RUN:     state_d = halt_cause ? HALTING : RUN;
         HALTING: state_d = count_q == '0 ? HALTED : HALTING;
         default: state_d = HALTED;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= RUN;
         wr_q        <= '0;
         rd_q        <= '0;
         count_q     <= '0;
         wdog_q      <= '0;
         halt_code_q <= '0;
         err_q       <= 1'b0;
         seen_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         count_q     <= count_d;
         wdog_q      <= wdog_d;
         halt_code_q <= halt_code_d;
         err_q       <= err_d;
         seen_q      <= seen_d;
      end
   end
   // Storage needs no reset: entries are only visible through count_q.
   always_ff @(posedge clock) mem_q <= mem_d;
`ifdef ECALL_COUNTERS_EN
   logic [63:0] cyc_q, cyc_d, ins_q, ins_d;
   always_comb begin
      cyc_d = done ? cyc_q : cyc_q + 64'd1;
      ins_d = accept ? ins_q + 64'd1 : ins_q;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         cyc_q <= '0;
         ins_q <= '0;
      end else begin
         cyc_q <= cyc_d;
         ins_q <= ins_d;
      end
   end
   assign cycle_count   = cyc_q;
   assign instret_count = ins_q;
`else
   assign cycle_count   = '0;
   assign instret_count = '0;
`endif
endmodule

// File: tb/tb_ecall_service_unit.sv
// tb_ecall_service_unit: directed self-checking bench for ecall_service_unit.
module tb_ecall_service_unit;
   logic        clock = 1'b0, reset = 1'b1, retire_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] instruction = 32'h13, pc = '0, a0 = '0, a1 = '0;
   logic        stall, out_valid, out_kind, halt, done, err;
   logic [31:0] out_data, halt_code;
   logic [63:0] cycle_count, instret_count;
   logic        wd_stall, wd_out_valid, wd_out_kind, wd_halt, wd_done, wd_err;
   logic [31:0] wd_out_data, wd_halt_code;
   logic [63:0] wd_cycle_count, wd_instret_count;
   int          n_chk = 0, n_pass = 0;
   logic [63:0] cyc_snap;
   logic [31:0] exp3 [3];
   always #5 clock = ~clock;
   ecall_service_unit #(.XLEN(32), .FIFO_DEPTH(8), .WDOG_CYCLES(0)) u_dut (
      .clock(clock), .reset(reset), .retire_valid(retire_valid), .instruction(instruction),
      .pc(pc), .a0(a0), .a1(a1), .stall(stall), .out_valid(out_valid), .out_kind(out_kind),
      .out_data(out_data), .out_ready(out_ready), .halt(halt), .done(done),
      .halt_code(halt_code), .err(err), .cycle_count(cycle_count), .instret_count(instret_count));
   ecall_service_unit #(.XLEN(32), .FIFO_DEPTH(8), .WDOG_CYCLES(16)) u_wd (
      .clock(clock), .reset(reset), .retire_valid(retire_valid), .instruction(instruction),
      .pc(pc), .a0(a0), .a1(a1), .stall(wd_stall), .out_valid(wd_out_valid), .out_kind(wd_out_kind),
      .out_data(wd_out_data), .out_ready(out_ready), .halt(wd_halt), .done(wd_done),
      .halt_code(wd_halt_code), .err(wd_err), .cycle_count(wd_cycle_count),
      .instret_count(wd_instret_count));
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   // Presents one retire for a single cycle, starting and ending at a falling edge.
   task automatic retire(input logic [31:0] p, input logic [31:0] c, input logic [31:0] arg, input logic ec);
      pc = p;
      a0 = c;
      a1 = arg;
      instruction = ec ? 32'h0000_0073 : 32'h0000_0013;
      retire_valid = 1'b1;
      @(negedge clock);
      retire_valid = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
   initial begin
      repeat (2) @(negedge clock);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_kind", out_kind, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_halt", halt, 0);
      chk("rst_done", done, 0);
      chk("rst_halt_code", halt_code, 0);
      chk("rst_err", err, 0);
      chk("rst_cycles", cycle_count, 0);
      chk("rst_instret", instret_count, 0);
      reset = 1'b0;
      retire(32'h4, 0, 0, 1'b0);
      // print-int of -5
      out_ready = 1'b1;
      retire(32'h8, 1, 32'hFFFF_FFFB, 1'b1);
      chk("int_valid", out_valid, 1);
      chk("int_kind", out_kind, 0);
      chk("int_data", out_data, 32'hFFFF_FFFB);
      @(negedge clock);
      chk("int_popped", out_valid, 0);
      // unknown service code
      retire(32'hC, 42, 5, 1'b1);
      chk("err_set", err, 1);
      chk("err_no_push", out_valid, 0);
      retire(32'h10, 0, 0, 1'b0);
      chk("err_sticky", err, 1);
      // fill FIFO with chars, ninth stalls
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) retire(32'h20 + 32'(4*i), 11, 32'hABCD_0041 + 32'(i), 1'b1);
      chk("full_head_kind", out_kind, 1);
      chk("full_head_data", out_data, 32'h41);
      pc = 32'h40; a0 = 11; a1 = 32'hABCD_0049; instruction = 32'h73; retire_valid = 1'b1;
      #1 chk("stall_full", stall, 1);
      @(negedge clock);
      chk("stall_held", stall, 1);
      chk("stall_no_push_head", out_data, 32'h41);
      out_ready = 1'b1;
      #1 chk("stall_with_pop", stall, 1);
      @(negedge clock);
      chk("stall_released", stall, 0);
      out_ready = 1'b0;
      @(negedge clock);
      retire_valid = 1'b0;
      chk("after_stall_head", out_data, 32'h42);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("drain_valid", out_valid, 1);
         chk("drain_data", out_data, 32'h42 + 32'(i));
         @(negedge clock);
      end
      chk("drain_empty", out_valid, 0);
      // exit with code 7 while 3 ints are queued
      out_ready = 1'b0;
      exp3[0] = 100; exp3[1] = 200; exp3[2] = 300;
      for (int i = 0; i < 3; i++) retire(32'h80 + 32'(4*i), 1, exp3[i], 1'b1);
      retire(32'h8C, 93, 7, 1'b1);
      chk("exit_halt", halt, 1);
      chk("exit_code", halt_code, 7);
      chk("exit_not_done", done, 0);
      retire(32'h90, 1, 999, 1'b1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("halting_data", out_data, 32'(exp3[i]));
         chk("halting_kind", out_kind, 0);
         @(negedge clock);
      end
      for (int k = 0; k < 4 && !done; k++) @(negedge clock);
      chk("exit_done", done, 1);
      chk("exit_no_late_push", out_valid, 0);
      chk("exit_halt_held", halt, 1);
`ifdef ECALL_COUNTERS_EN
      chk("instret", instret_count, 17);
      cyc_snap = cycle_count;
      repeat (3) @(negedge clock);
      chk("cycles_frozen", cycle_count, cyc_snap);
`endif
      // reset in the middle of HALTING with 4 entries queued
      out_ready = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      retire(32'h0, 0, 0, 1'b0);
      chk("pc0_first_no_halt", halt, 0);
      for (int i = 0; i < 4; i++) retire(32'h4 + 32'(4*i), 1, 32'(i), 1'b1);
      retire(32'h14, 10, 55, 1'b1);
      chk("exit10_halt", halt, 1);
      chk("exit10_code", halt_code, 0);
      @(negedge clock);
      chk("halting_not_done", done, 0);
      chk("halting_valid", out_valid, 1);
      reset = 1'b1;
      @(negedge clock);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_halt", halt, 0);
      chk("mid_rst_code", halt_code, 0);
      chk("mid_rst_err", err, 0);
      chk("mid_rst_cycles", cycle_count, 0);
      chk("mid_rst_instret", instret_count, 0);
      reset = 1'b0;
      // pc-zero halt after an earlier retire
      retire(32'h4, 0, 0, 1'b0);
      chk("pre_pc0_halt", halt, 0);
      retire(32'h0, 0, 0, 1'b0);
      chk("pc0_halt", halt, 1);
      chk("pc0_code", halt_code, 32'hFFFF_FFFF);
      // watchdog: 16 idle cycles
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      repeat (15) @(negedge clock);
      chk("wdog_before", wd_halt, 0);
      @(negedge clock);
      chk("wdog_halt", wd_halt, 1);
      chk("wdog_code", wd_halt_code, 32'hDEAD_0001);
      chk("wdog_disabled", halt, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
